// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider: LO = RA / RB, HI = RA % RB, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (adds the FIX sign-correction state).
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] RA,
  input  logic [31:0] RB,
  output logic [31:0] LO,
  output logic [31:0] HI,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic [5:0]  cnt;
  logic        accept;
  logic        last_step;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  function automatic logic [31:0] negate(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // Magnitude of the most negative value wraps to itself, which is still correct as unsigned.
  assign a_mag = RA[31] ? negate(RA) : RA;
  assign b_mag = RB[31] ? negate(RB) : RB;
`else
  assign a_mag = RA;
  assign b_mag = RB;
`endif

  assign accept    = ((state == IDLE) || (state == DONE)) && start;
  assign last_step = (cnt == 6'd31);

  // The dividend lives in the quotient register and shifts into the remainder as quotient bits shift in.
  always_comb begin
    rem_sh  = {rem, quo[31]};
    trial   = rem_sh - {1'b0, dvsr};
    rem_nxt = trial[32] ? rem_sh[31:0] : trial[31:0];
    quo_nxt = {quo[30:0], ~trial[32]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start)              state_nxt = (RB == 32'd0) ? DONE : RUN;
        else if (state == DONE) state_nxt = IDLE;
      end
      RUN: begin
`ifdef DIV_SIGNED_EN
        if (last_step) state_nxt = FIX;
`else
        if (last_step) state_nxt = DONE;
`endif
      end
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FIX);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      LO          <= 32'd0;
      HI          <= 32'd0;
      rem         <= 32'd0;
      quo         <= 32'd0;
      dvsr        <= 32'd0;
      cnt         <= 6'd0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else if (accept) begin
      rem         <= 32'd0;
      quo         <= a_mag;
      dvsr        <= b_mag;
      cnt         <= 6'd0;
      div_by_zero <= (RB == 32'd0);
`ifdef DIV_SIGNED_EN
      neg_q       <= RA[31] ^ RB[31];
      neg_r       <= RA[31];
`endif
      // Divide-by-zero bypasses RUN; the raw dividend is reported as the remainder.
      if (RB == 32'd0) begin
        LO <= 32'hFFFF_FFFF;
        HI <= RA;
      end
    end else if (state == RUN) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt + 6'd1;
`ifndef DIV_SIGNED_EN
      if (last_step) begin
        LO <= quo_nxt;
        HI <= rem_nxt;
      end
`endif
    end
`ifdef DIV_SIGNED_EN
    else if (state == FIX) begin
      LO <= neg_q ? negate(quo) : quo;
      HI <= neg_r ? negate(rem) : rem;
    end
`endif
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: driver pushes reference results, negedge monitor pops on done.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] RA, RB;
  logic [31:0] LO, HI;
  logic        busy, done, div_by_zero;

  div_seq dut (
    .clk(clk), .rst(rst), .start(start), .RA(RA), .RB(RB),
    .LO(LO), .HI(HI), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

`ifdef DIV_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          pcyc = 0;
  int          busy_cnt = 0;
  bit          mon_en = 0;
  bit          abort = 0;
  logic [31:0] held_lo = 32'd0;
  logic [31:0] held_hi = 32'd0;

  always @(posedge clk) pcyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, 64-bit so the most-negative / -1 case simply wraps.
  task automatic model(input logic [31:0] a, input logic [31:0] b, output exp_t e);
    longint sa, sb2;
`ifdef DIV_SIGNED_EN
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
`else
    sa  = longint'({32'd0, a});
    sb2 = longint'({32'd0, b});
`endif
    e.t0 = pcyc;
    if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF; e.hi = a; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.lo = 32'(sa / sb2); e.hi = 32'(sa % sb2); e.dbz = 1'b0; e.lat = LAT;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL busy_timeout: got busy=%b want 0", busy);
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    wait_idle();
    model(a, b, e);
    sb.push_back(e);
    RA = a; RB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done=1 want no done");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("lo", LO, e.lo);
          chk("hi", HI, e.hi);
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
          chk("latency", 32'(pcyc - e.t0), 32'(e.lat));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.lat - 1));
          held_lo = e.lo;
          held_hi = e.hi;
        end
        busy_cnt = 0;
        if (busy) begin
          total++; bad++;
          $display("FAIL busy_with_done: got busy=1 want 0");
        end
      end else if (!abort) begin
        chk("lo_hold", LO, held_lo);
        chk("hi_hold", HI, held_hi);
      end
      if (busy && !abort) busy_cnt++;
    end
  end

  initial begin
    logic [31:0] a, b;
    int n;
    rst = 1'b1; start = 1'b0; RA = 32'd0; RB = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_lo", LO, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    do_op(32'd100, 32'd7);
    do_op(32'hFFFF_FFFF, 32'd1);
    do_op(32'd5, 32'd9);
    do_op(32'h1234, 32'd0);
    do_op(32'hFFFF_FFF9, 32'd2);
    do_op(32'd7, 32'hFFFF_FFFE);
    do_op(32'h8000_0000, 32'hFFFF_FFFF);
    do_op(32'h8000_0000, 32'd0);

    // Start raised mid-operation must be ignored; then a back-to-back op in the done cycle.
    do_op(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    RA = 32'd9; RB = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_op(32'd50, 32'd5);

    // Reset during RUN aborts the operation with no done.
    wait_idle();
    abort = 1'b1;
    RA = 32'd1000; RB = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_lo", LO, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    held_lo = 32'd0; held_hi = 32'd0; busy_cnt = 0;
    abort = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: b = $urandom;
      endcase
      do_op(a, b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
